// File: rtl/cache_assoc_wb_if.sv
// Processor request/response and main-memory handshake bundle for cache_assoc_wb.
// The slave modport is the cache's view; the master modport is the surrounding system's view.
interface cache_assoc_wb_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic              req_valid_in;
    logic              req_ready_out;
    logic              req_wren_in;
    logic [ADDR_W-1:0] req_addr_in;
    logic [DATA_W-1:0] req_data_in;
    logic              resp_valid_out;
    logic [DATA_W-1:0] resp_data_out;
    logic              resp_hit_out;
    logic              mem_req_out;
    logic              mem_wren_out;
    logic [ADDR_W-1:0] mem_addr_out;
    logic [DATA_W-1:0] mem_data_out;
    logic              mem_ack_in;
    logic [DATA_W-1:0] mem_data_in;

    modport slave (
        input  req_valid_in, req_wren_in, req_addr_in, req_data_in, mem_ack_in, mem_data_in,
        output req_ready_out, resp_valid_out, resp_data_out, resp_hit_out,
               mem_req_out, mem_wren_out, mem_addr_out, mem_data_out
    );

    modport master (
        output req_valid_in, req_wren_in, req_addr_in, req_data_in, mem_ack_in, mem_data_in,
        input  req_ready_out, resp_valid_out, resp_data_out, resp_hit_out,
               mem_req_out, mem_wren_out, mem_addr_out, mem_data_out
    );
endinterface

// File: rtl/cache_assoc_wb.sv
// N-way set-associative write-back, write-allocate cache with true LRU per set,
// one word per line, req/ack miss handling and saturating hit/miss counters.
module cache_assoc_wb #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int WAYS   = 4,
    parameter int SETS   = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clock_in,
    input  logic             reset_in,
    cache_assoc_wb_if.slave  bus,
    output logic [CNT_W-1:0] hit_count_out,
    output logic [CNT_W-1:0] miss_count_out
);
    localparam int SET_W  = (SETS > 1) ? $clog2(SETS) : 0;
    localparam int SIDX_W = (SET_W > 0) ? SET_W : 1;
    localparam int TAG_W  = ADDR_W - SET_W;
    localparam int WAY_W  = $clog2(WAYS);
    localparam logic [WAY_W-1:0] AGE_MAX = WAY_W'(WAYS - 1);

    typedef enum logic [2:0] {IDLE, LOOKUP, WRBACK, FILL, RESP} state_t;

    state_t r_state;
    state_t w_next;

    logic              r_valid [SETS][WAYS];
    logic              r_dirty [SETS][WAYS];
    logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
    logic [DATA_W-1:0] r_data  [SETS][WAYS];
    logic [WAY_W-1:0]  r_age   [SETS][WAYS];

    logic              r_wren;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_fillData;
    logic [WAY_W-1:0]  r_victim;
    logic              r_respValid;
    logic              r_respHit;
    logic [DATA_W-1:0] r_respData;
    logic [CNT_W-1:0]  r_hitCount;
    logic [CNT_W-1:0]  r_missCount;

    logic [SIDX_W-1:0] w_set;
    logic [TAG_W-1:0]  w_tag;
    logic [ADDR_W-1:0] w_wbAddr;
    logic              w_hit;
    logic [WAY_W-1:0]  w_hitWay;
    logic              w_invFound;
    logic [WAY_W-1:0]  w_invWay;
    logic [WAY_W-1:0]  w_lruWay;
    logic [WAY_W-1:0]  w_victim;
    logic              w_touch;
    logic [WAY_W-1:0]  w_touchWay;
    logic [DATA_W-1:0] w_installData;

    // A single-set cache has no index bits: the whole address is the tag.
    if (SETS > 1) begin : g_sets
        assign w_set    = r_addr[SET_W-1:0];
        assign w_tag    = r_addr[ADDR_W-1:SET_W];
        assign w_wbAddr = {r_tag[w_set][r_victim], w_set};
    end else begin : g_noSets
        assign w_set    = 1'b0;
        assign w_tag    = r_addr;
        assign w_wbAddr = r_tag[0][r_victim];
    end

    always_comb begin
        w_hit      = 1'b0;
        w_hitWay   = '0;
        w_invFound = 1'b0;
        w_invWay   = '0;
        w_lruWay   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w_set][w] && (r_tag[w_set][w] == w_tag)) begin
                w_hit    = 1'b1;
                w_hitWay = WAY_W'(w);
            end
            if (!w_invFound && !r_valid[w_set][w]) begin
                w_invFound = 1'b1;
                w_invWay   = WAY_W'(w);
            end
            if (r_age[w_set][w] == AGE_MAX) begin
                w_lruWay = WAY_W'(w);
            end
        end
        w_victim = w_invFound ? w_invWay : w_lruWay;
    end

    assign w_touch       = ((r_state == LOOKUP) && w_hit) || (r_state == RESP);
    assign w_touchWay    = (r_state == RESP) ? r_victim : w_hitWay;
    assign w_installData = r_wren ? r_wdata : r_fillData;

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next            = r_state;
        bus.req_ready_out = 1'b0;
        bus.mem_req_out   = 1'b0;
        bus.mem_wren_out  = 1'b0;
        bus.mem_addr_out  = '0;
        bus.mem_data_out  = '0;
        case (r_state)
            IDLE: begin
                bus.req_ready_out = 1'b1;
                if (bus.req_valid_in) w_next = LOOKUP;
            end
            LOOKUP: begin
                if (w_hit)                                               w_next = IDLE;
                else if (r_valid[w_set][w_victim] && r_dirty[w_set][w_victim]) w_next = WRBACK;
                else if (r_wren)                                         w_next = RESP;
                else                                                     w_next = FILL;
            end
            WRBACK: begin
                bus.mem_req_out  = 1'b1;
                bus.mem_wren_out = 1'b1;
                bus.mem_addr_out = w_wbAddr;
                bus.mem_data_out = r_data[w_set][r_victim];
                if (bus.mem_ack_in) w_next = r_wren ? RESP : FILL;
            end
            FILL: begin
                bus.mem_req_out  = 1'b1;
                bus.mem_addr_out = r_addr;
                if (bus.mem_ack_in) w_next = RESP;
            end
            RESP: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Storage, LRU ages, response registers and counters; all keyed off the current state.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            r_wren      <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_fillData  <= '0;
            r_victim    <= '0;
            r_respValid <= 1'b0;
            r_respHit   <= 1'b0;
            r_respData  <= '0;
            r_hitCount  <= '0;
            r_missCount <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    r_valid[s][w] <= 1'b0;
                    r_dirty[s][w] <= 1'b0;
                    r_tag[s][w]   <= '0;
                    r_data[s][w]  <= '0;
                    r_age[s][w]   <= WAY_W'(w);
                end
            end
        end else begin
            r_respValid <= 1'b0;
            if (w_touch) begin
                for (int v = 0; v < WAYS; v++) begin
                    if (WAY_W'(v) == w_touchWay) begin
                        r_age[w_set][v] <= '0;
                    end else if (r_age[w_set][v] < r_age[w_set][w_touchWay]) begin
                        r_age[w_set][v] <= r_age[w_set][v] + 1'b1;
                    end
                end
            end
            case (r_state)
                IDLE: begin
                    if (bus.req_valid_in) begin
                        r_wren  <= bus.req_wren_in;
                        r_addr  <= bus.req_addr_in;
                        r_wdata <= bus.req_data_in;
                    end
                end
                LOOKUP: begin
                    if (w_hit) begin
                        if (r_wren) begin
                            r_data[w_set][w_hitWay]  <= r_wdata;
                            r_dirty[w_set][w_hitWay] <= 1'b1;
                        end
                        r_respData  <= r_wren ? r_wdata : r_data[w_set][w_hitWay];
                        r_respValid <= 1'b1;
                        r_respHit   <= 1'b1;
                        if (r_hitCount != '1) r_hitCount <= r_hitCount + 1'b1;
                    end else begin
                        r_victim <= w_victim;
                        if (r_missCount != '1) r_missCount <= r_missCount + 1'b1;
                    end
                end
                WRBACK: begin
                    if (bus.mem_ack_in) r_dirty[w_set][r_victim] <= 1'b0;
                end
                FILL: begin
                    if (bus.mem_ack_in) r_fillData <= bus.mem_data_in;
                end
                RESP: begin
                    r_valid[w_set][r_victim] <= 1'b1;
                    r_dirty[w_set][r_victim] <= r_wren;
                    r_tag[w_set][r_victim]   <= w_tag;
                    r_data[w_set][r_victim]  <= w_installData;
                    r_respData               <= w_installData;
                    r_respValid              <= 1'b1;
                    r_respHit                <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.resp_valid_out = r_respValid;
    assign bus.resp_hit_out   = r_respHit;
    assign bus.resp_data_out  = r_respData;
    assign hit_count_out      = r_hitCount;
    assign miss_count_out     = r_missCount;
endmodule

// File: tb/tb_cache_assoc_wb.sv
// Scoreboard bench for cache_assoc_wb: directed requests push expected responses and
// expected memory transactions; a response monitor and a memory responder check them.
module tb_cache_assoc_wb;
    typedef struct {
        logic [7:0] data;
        logic       hit;
        int         lat;
    } resp_t;

    typedef struct {
        logic       wren;
        logic [4:0] addr;
        logic [7:0] wdata;
        logic [7:0] fill;
        int         delay;
    } mem_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] hitCount;
    logic [15:0] missCount;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          acceptCycle = 0;
    resp_t       respQ[$];
    mem_t        memQ[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cache_assoc_wb_if #(.ADDR_W(5), .DATA_W(8)) bus ();

    cache_assoc_wb #(
        .ADDR_W(5), .DATA_W(8), .WAYS(4), .SETS(2), .CNT_W(16)
    ) dut (
        .clock_in       (clk),
        .reset_in       (rst),
        .bus            (bus),
        .hit_count_out  (hitCount),
        .miss_count_out (missCount)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expectMem(input logic wr, input logic [4:0] a, input logic [7:0] wd,
                             input logic [7:0] fill, input int delay);
        memQ.push_back('{wr, a, wd, fill, delay});
    endtask

    task automatic issueReq(input logic wr, input logic [4:0] a, input logic [7:0] d,
                            input logic [7:0] expData, input logic expHit, input int lat);
        int guard = 0;
        @(negedge clk);
        while (bus.req_ready_out !== 1'b1 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) checkOutput("readyTimeout", 32'd0, 32'd1);
        bus.req_valid_in = 1'b1;
        bus.req_wren_in  = wr;
        bus.req_addr_in  = a;
        bus.req_data_in  = d;
        respQ.push_back('{expData, expHit, lat});
        @(posedge clk);
        #1;
        acceptCycle      = cyc;
        bus.req_valid_in = 1'b0;
    endtask

    task automatic waitDone();
        int guard = 0;
        do begin
            @(negedge clk);
            #1;
            guard++;
        end while (respQ.size() != 0 && guard < 300);
        if (respQ.size() != 0) begin
            checkOutput("respTimeout", 32'd0, 32'd1);
            respQ.delete();
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic [4:0] a, input logic [7:0] d,
                                 input logic [7:0] expData, input logic expHit);
        issueReq(wr, a, d, expData, expHit, expHit ? 1 : 0);
        waitDone();
    endtask

    // Response monitor: every response must match the oldest outstanding expectation.
    always @(negedge clk) begin
        resp_t r;
        if (rst === 1'b0 && bus.resp_valid_out === 1'b1) begin
            if (respQ.size() == 0) begin
                checkOutput("unexpectedResp", 32'd1, 32'd0);
            end else begin
                r = respQ.pop_front();
                checkOutput("respData", 32'(bus.resp_data_out), 32'(r.data));
                checkOutput("respHit", 32'(bus.resp_hit_out), 32'(r.hit));
                if (r.lat != 0) checkOutput("respLatency", cyc - acceptCycle, r.lat);
            end
        end
    end

    // Memory responder: checks each request against the expected list, stalls, then acks.
    initial begin
        mem_t m;
        bit   aborted;
        bus.mem_ack_in  = 1'b0;
        bus.mem_data_in = 8'h00;
        forever begin
            @(negedge clk);
            while (bus.mem_req_out === 1'b1 && rst === 1'b0) begin
                if (memQ.size() == 0) begin
                    checkOutput("unexpectedMemReq", 32'd1, 32'd0);
                    m = '{bus.mem_wren_out, bus.mem_addr_out, bus.mem_data_out, 8'h00, 0};
                end else begin
                    m = memQ.pop_front();
                    checkOutput("memWren", 32'(bus.mem_wren_out), 32'(m.wren));
                    checkOutput("memAddr", 32'(bus.mem_addr_out), 32'(m.addr));
                    if (m.wren) checkOutput("memWbData", 32'(bus.mem_data_out), 32'(m.wdata));
                end
                aborted = 1'b0;
                for (int d = 0; d < m.delay; d++) begin
                    @(negedge clk);
                    if (rst === 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    checkOutput("memReqHeld", 32'(bus.mem_req_out), 32'd1);
                    checkOutput("memAddrHeld", 32'(bus.mem_addr_out), 32'(m.addr));
                    checkOutput("readyLowInMiss", 32'(bus.req_ready_out), 32'd0);
                end
                if (!aborted) begin
                    bus.mem_ack_in  = 1'b1;
                    bus.mem_data_in = m.fill;
                    @(negedge clk);
                    bus.mem_ack_in  = 1'b0;
                    bus.mem_data_in = 8'h00;
                    if (!m.wren) checkOutput("memReqDrop", 32'(bus.mem_req_out), 32'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst              = 1'b1;
        bus.req_valid_in = 1'b0;
        bus.req_wren_in  = 1'b0;
        bus.req_addr_in  = 5'h00;
        bus.req_data_in  = 8'h00;
        repeat (2) @(negedge clk);
        checkOutput("rstReady", 32'(bus.req_ready_out), 32'd1);
        checkOutput("rstRespValid", 32'(bus.resp_valid_out), 32'd0);
        checkOutput("rstMemReq", 32'(bus.mem_req_out), 32'd0);
        checkOutput("rstHitCount", 32'(hitCount), 32'd0);
        checkOutput("rstMissCount", 32'(missCount), 32'd0);
        rst = 1'b0;

        $display("[TB] cold read miss then hit");
        expectMem(1'b0, 5'h04, 8'h00, 8'hA5, 0);
        applyStimulus(1'b0, 5'h04, 8'h00, 8'hA5, 1'b0);
        applyStimulus(1'b0, 5'h04, 8'h00, 8'hA5, 1'b1);

        $display("[TB] write hit");
        applyStimulus(1'b1, 5'h04, 8'h3C, 8'h3C, 1'b1);
        checkOutput("hitCountAfterWrite", 32'(hitCount), 32'd2);
        checkOutput("missCountAfterWrite", 32'(missCount), 32'd1);
        applyStimulus(1'b0, 5'h04, 8'h00, 8'h3C, 1'b1);
        checkOutput("hitCountAfterRead", 32'(hitCount), 32'd3);

        // Set 0 holds 0x04 (dirty) in way 0; fill the rest and exercise LRU victim choice.
        $display("[TB] LRU replacement");
        expectMem(1'b0, 5'h00, 8'h00, 8'h10, 0);
        applyStimulus(1'b0, 5'h00, 8'h00, 8'h10, 1'b0);
        expectMem(1'b0, 5'h02, 8'h00, 8'h20, 0);
        applyStimulus(1'b0, 5'h02, 8'h00, 8'h20, 1'b0);
        applyStimulus(1'b0, 5'h04, 8'h00, 8'h3C, 1'b1);
        expectMem(1'b0, 5'h06, 8'h00, 8'h30, 0);
        applyStimulus(1'b0, 5'h06, 8'h00, 8'h30, 1'b0);
        applyStimulus(1'b0, 5'h00, 8'h00, 8'h10, 1'b1);
        expectMem(1'b0, 5'h08, 8'h00, 8'h40, 0);
        applyStimulus(1'b0, 5'h08, 8'h00, 8'h40, 1'b0);
        expectMem(1'b1, 5'h04, 8'h3C, 8'h00, 0);
        expectMem(1'b0, 5'h02, 8'h00, 8'h22, 0);
        applyStimulus(1'b0, 5'h02, 8'h00, 8'h22, 1'b0);

        $display("[TB] write miss and dirty eviction");
        applyStimulus(1'b1, 5'h0A, 8'h11, 8'h11, 1'b0);
        expectMem(1'b0, 5'h0C, 8'h00, 8'h50, 0);
        applyStimulus(1'b0, 5'h0C, 8'h00, 8'h50, 1'b0);
        expectMem(1'b0, 5'h0E, 8'h00, 8'h51, 0);
        applyStimulus(1'b0, 5'h0E, 8'h00, 8'h51, 1'b0);
        expectMem(1'b0, 5'h10, 8'h00, 8'h52, 0);
        applyStimulus(1'b0, 5'h10, 8'h00, 8'h52, 1'b0);
        expectMem(1'b1, 5'h0A, 8'h11, 8'h00, 0);
        expectMem(1'b0, 5'h12, 8'h00, 8'h53, 0);
        applyStimulus(1'b0, 5'h12, 8'h00, 8'h53, 1'b0);

        $display("[TB] stalled fill with ignored request");
        expectMem(1'b0, 5'h14, 8'h00, 8'h60, 5);
        issueReq(1'b0, 5'h14, 8'h00, 8'h60, 1'b0, 0);
        repeat (2) @(negedge clk);
        bus.req_valid_in = 1'b1;
        bus.req_wren_in  = 1'b0;
        bus.req_addr_in  = 5'h00;
        @(negedge clk);
        bus.req_valid_in = 1'b0;
        waitDone();
        applyStimulus(1'b0, 5'h14, 8'h00, 8'h60, 1'b1);
        checkOutput("hitCountTotal", 32'(hitCount), 32'd6);
        checkOutput("missCountTotal", 32'(missCount), 32'd12);

        $display("[TB] reset during fill");
        expectMem(1'b0, 5'h16, 8'h00, 8'h77, 40);
        issueReq(1'b0, 5'h16, 8'h00, 8'h77, 1'b0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midRstMemReq", 32'(bus.mem_req_out), 32'd0);
        checkOutput("midRstReady", 32'(bus.req_ready_out), 32'd1);
        checkOutput("midRstHitCount", 32'(hitCount), 32'd0);
        checkOutput("midRstMissCount", 32'(missCount), 32'd0);
        respQ.delete();
        repeat (2) @(negedge clk);
        memQ.delete();
        rst = 1'b0;
        expectMem(1'b0, 5'h14, 8'h00, 8'h61, 0);
        applyStimulus(1'b0, 5'h14, 8'h00, 8'h61, 1'b0);
        checkOutput("postRstHitCount", 32'(hitCount), 32'd0);
        checkOutput("postRstMissCount", 32'(missCount), 32'd1);
        checkOutput("memQueueDrained", memQ.size(), 32'd0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
